// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline with a multi-cycle data memory handshake.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   IDEX_MemRead_i, IDEX_rd_i, IFID_rs1_i, IFID_rs2_i : load-use detection inputs
//   branch_taken_i : branch resolved taken in ID
//   EXMEM_mem_i, mem_ack_i : MEM-stage access present / data memory done
//   pc_we_o, IFID_we_o, IDEX_we_o, EXMEM_we_o, MEMWB_we_o : pipeline register write enables
//   IFID_flush_o, IDEX_bubble_o : NOP insertion controls
//   mem_req_o : one-cycle access strobe; err_o : sticky memory timeout
// Optional: PIPE_PERF_CNT_EN adds stall_cnt_o / flush_cnt_o performance counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_rd_i,
  input  logic [4:0] IFID_rs1_i,
  input  logic [4:0] IFID_rs2_i,
  input  logic       branch_taken_i,
  input  logic       EXMEM_mem_i,
  input  logic       mem_ack_i,
  output logic       pc_we_o,
  output logic       IFID_we_o,
  output logic       IFID_flush_o,
  output logic       IDEX_we_o,
  output logic       IDEX_bubble_o,
  output logic       EXMEM_we_o,
  output logic       MEMWB_we_o,
  output logic       mem_req_o,
  output logic       err_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);
  typedef enum logic [1:0] {RUN, WAIT, DONE, HALT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_use, flow;
  // flow: pipeline advances this cycle; DONE behaves as RUN with no MEM access so the access retires
  always_comb begin
    load_use = IDEX_MemRead_i & (IDEX_rd_i != 5'd0) & ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i));
    flow = rst_i & (((state_q == RUN) & ~EXMEM_mem_i) | (state_q == DONE));
    pc_we_o = flow & ~load_use;
    IFID_we_o = flow & ~load_use;
    IFID_flush_o = flow & ~load_use & branch_taken_i;
    IDEX_we_o = flow;
    IDEX_bubble_o = flow & load_use;
    EXMEM_we_o = flow;
    MEMWB_we_o = flow;
    mem_req_o = rst_i & (state_q == RUN) & EXMEM_mem_i;
    err_o = rst_i & (state_q == HALT);
  end
  // ack is only looked at in WAIT, so an ack coincident with the request is dropped
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      RUN: begin
        state_d = EXMEM_mem_i ? WAIT : RUN;
        cnt_d = EXMEM_mem_i ? '0 : cnt_q;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        state_d = mem_ack_i ? DONE : (cnt_q == CNT_W'(TIMEOUT - 1)) ? HALT : WAIT;
      end
      DONE: state_d = RUN;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  // a stall cycle is any non-flowing cycle out of reset, or a load-use bubble
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + {31'd0, ~flow | load_use};
      flush_cnt_o <= flush_cnt_o + {31'd0, IFID_flush_o};
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl against a behavioural pipeline-control model.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 255;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic IDEX_MemRead_i = 1'b0;
  logic [4:0] IDEX_rd_i = '0;
  logic [4:0] IFID_rs1_i = '0;
  logic [4:0] IFID_rs2_i = '0;
  logic branch_taken_i = 1'b0;
  logic EXMEM_mem_i = 1'b0;
  logic mem_ack_i = 1'b0;
  logic pc_we_o, IFID_we_o, IFID_flush_o, IDEX_we_o, IDEX_bubble_o;
  logic EXMEM_we_o, MEMWB_we_o, mem_req_o, err_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif
  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_rd_i(IDEX_rd_i),
    .IFID_rs1_i(IFID_rs1_i),
    .IFID_rs2_i(IFID_rs2_i),
    .branch_taken_i(branch_taken_i),
    .EXMEM_mem_i(EXMEM_mem_i),
    .mem_ack_i(mem_ack_i),
    .pc_we_o(pc_we_o),
    .IFID_we_o(IFID_we_o),
    .IFID_flush_o(IFID_flush_o),
    .IDEX_we_o(IDEX_we_o),
    .IDEX_bubble_o(IDEX_bubble_o),
    .EXMEM_we_o(EXMEM_we_o),
    .MEMWB_we_o(MEMWB_we_o),
    .mem_req_o(mem_req_o),
    .err_o(err_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [8:0] o;
    logic [31:0] sc;
    logic [31:0] fc;
    bit perf;
  } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  // model: an access in flight counts its elapsed wait cycles; a retiring access lets the pipe flow once
  bit in_acc = 0;
  bit retiring = 0;
  bit halted = 0;
  int waited = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  task automatic step(input bit r, input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit br, input bit mem, input bit ack);
    exp_t e;
    bit lu;
    @(negedge clk);
    rst_i = r;
    IDEX_MemRead_i = mr;
    IDEX_rd_i = rd;
    IFID_rs1_i = rs1;
    IFID_rs2_i = rs2;
    branch_taken_i = br;
    EXMEM_mem_i = mem;
    mem_ack_i = ack;
    e.cyc = cyc;
    e.o = '0;
    e.sc = m_stall;
    e.fc = m_flush;
    e.perf = r;
    if (!r) begin
      in_acc = 0;
      retiring = 0;
      halted = 0;
      waited = 0;
      m_stall = '0;
      m_flush = '0;
    end else if (halted) begin
      e.o = 9'b0_0000_0001;
      m_stall++;
    end else if (in_acc) begin
      m_stall++;
      waited++;
      if (ack) begin
        in_acc = 0;
        retiring = 1;
      end else if (waited == TIMEOUT) halted = 1;
    end else if (mem && !retiring) begin
      e.o = 9'b0_0000_0010;
      in_acc = 1;
      waited = 0;
      m_stall++;
    end else begin
      retiring = 0;
      lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
      e.o = {!lu, !lu, !lu && br, 1'b1, lu, 1'b1, 1'b1, 1'b0, 1'b0};
      if (lu) m_stall++;
      else if (br) m_flush++;
    end
    q.push_back(e);
    cyc++;
  endtask
  task automatic rnd_step();
    step($urandom_range(0, 99) != 0, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
         5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
  endtask
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_we_o, IFID_we_o, IFID_flush_o, IDEX_we_o, IDEX_bubble_o, EXMEM_we_o, MEMWB_we_o, mem_req_o, err_o};
        n_tests++;
        if (act !== e.o) begin
          n_fail++;
          $display("FAIL outs cyc %0d: got %b expected %b (pc,ifid,flush,idex,bubble,exmem,memwb,req,err)", e.cyc, act, e.o);
        end
`ifdef PIPE_PERF_CNT_EN
        if (e.perf) begin
          n_tests++;
          if (stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
            n_fail++;
            $display("FAIL perf cyc %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d", e.cyc, stall_cnt_o, flush_cnt_o, e.sc, e.fc);
          end
        end
`endif
      end
    end
  end
  initial begin
    // reset held with a pending MEM access, then the request fires on release
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // load-use beats branch; rd=0 never stalls
    step(1, 1, 5, 0, 5, 1, 0, 0);
    step(1, 1, 5, 5, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 5, 3, 4, 0, 0, 0);
    // ack only in the request cycle, then silence until timeout and sticky error
    step(1, 0, 0, 0, 0, 0, 1, 1);
    repeat (TIMEOUT + 5) step(1, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a wait aborts the access
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    // counter scenario: one load-use, one 3-cycle access, two branch flushes
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 7, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (4000) rnd_step();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #5;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
